// File: rtl/ccmul_pipe.sv
// Four-stage complex coefficient multiplier, (x + jy) * (c + js) or its conjugate form,
// using the 3-multiply factorisation, with round-half-up, saturation and overflow flags.
module ccmul_pipe #(
    parameter int W    = 8,
    parameter int WO   = 8,
    parameter int FRAC = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                conj,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    input  logic signed [W-1:0] c_in,
    input  logic signed [W:0]   cps_in,
    input  logic signed [W:0]   cms_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [WO-1:0] r_out,
    output logic signed [WO-1:0] i_out,
    output logic                ovf,
    output logic                ovf_sticky,
    input  logic                ovf_clr
);
    localparam int WP     = 2*W + 1;
    localparam int WS     = 2*W + 2;
    localparam int WV     = 2*W + 3;
    localparam int RND_SH = (FRAC > 0) ? FRAC - 1 : 0;
    localparam logic signed [WV-1:0] RND  = (FRAC > 0) ? (WV'(1) <<< RND_SH) : '0;
    localparam logic signed [WV-1:0] SMAX = (WV'(1) <<< (WO - 1)) - WV'(1);
    localparam logic signed [WV-1:0] SMIN = -SMAX - WV'(1);

    logic                 advance;
    logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
    logic signed [W-1:0]  x1_q, x1_d, y1_q, y1_d, c1_q, c1_d;
    logic signed [W:0]    cps1_q, cps1_d, cms1_q, cms1_d, xmy1_q, xmy1_d;
    logic signed [WP-1:0] xmyc2_q, xmyc2_d, cmsy2_q, cmsy2_d, cpsx2_q, cpsx2_d;
    logic signed [WS-1:0] r3_q, r3_d, i3_q, i3_d;
    logic signed [WO-1:0] r4_q, r4_d, i4_q, i4_d;
    logic                 ovf_q, ovf_d, ovf_sticky_q, ovf_sticky_d;
    logic signed [WO-1:0] r_sat, i_sat;
    logic                 r_clip, i_clip;

    // Round half toward +inf via bias-then-arithmetic-shift, then clamp to the output range.
    function automatic void scale_sat(input logic signed [WS-1:0] v,
                                      output logic signed [WO-1:0] t,
                                      output logic clip);
        logic signed [WV-1:0] sh;
        sh = (WV'(v) + RND) >>> FRAC;
        clip = 1'b1;
        if (sh > SMAX)      t = SMAX[WO-1:0];
        else if (sh < SMIN) t = SMIN[WO-1:0];
        else begin
            t    = sh[WO-1:0];
            clip = 1'b0;
        end
    endfunction

    always_comb begin
        advance      = !v4_q || out_ready;
        v1_d = v1_q;  v2_d = v2_q;  v3_d = v3_q;  v4_d = v4_q;
        x1_d = x1_q;  y1_d = y1_q;  c1_d = c1_q;
        cps1_d = cps1_q;  cms1_d = cms1_q;  xmy1_d = xmy1_q;
        xmyc2_d = xmyc2_q;  cmsy2_d = cmsy2_q;  cpsx2_d = cpsx2_q;
        r3_d = r3_q;  i3_d = i3_q;
        r4_d = r4_q;  i4_d = i4_q;  ovf_d = ovf_q;
        scale_sat(r3_q, r_sat, r_clip);
        scale_sat(i3_q, i_sat, i_clip);

        if (advance) begin
            v1_d = in_valid;
            v2_d = v1_q;
            v3_d = v2_q;
            v4_d = v3_q;
            if (in_valid) begin
                x1_d   = x_in;
                y1_d   = y_in;
                c1_d   = c_in;
                // Conjugating the coefficient negates s, which just swaps c+s and c-s.
                cps1_d = conj ? cms_in : cps_in;
                cms1_d = conj ? cps_in : cms_in;
                xmy1_d = (W+1)'(x_in) - (W+1)'(y_in);
            end
            xmyc2_d = WP'(xmy1_q) * WP'(c1_q);
            cmsy2_d = WP'(cms1_q) * WP'(y1_q);
            cpsx2_d = WP'(cps1_q) * WP'(x1_q);
            r3_d    = WS'(cmsy2_q) + WS'(xmyc2_q);
            i3_d    = WS'(cpsx2_q) - WS'(xmyc2_q);
            r4_d    = r_sat;
            i4_d    = i_sat;
            ovf_d   = v3_q && (r_clip || i_clip);
        end

        ovf_sticky_d = ovf_sticky_q;
        if (ovf_clr)                    ovf_sticky_d = 1'b0;
        if (v4_q && out_ready && ovf_q) ovf_sticky_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q <= 1'b0;  v2_q <= 1'b0;  v3_q <= 1'b0;  v4_q <= 1'b0;
            x1_q <= '0;  y1_q <= '0;  c1_q <= '0;
            cps1_q <= '0;  cms1_q <= '0;  xmy1_q <= '0;
            xmyc2_q <= '0;  cmsy2_q <= '0;  cpsx2_q <= '0;
            r3_q <= '0;  i3_q <= '0;
            r4_q <= '0;  i4_q <= '0;
            ovf_q <= 1'b0;  ovf_sticky_q <= 1'b0;
        end else begin
            v1_q <= v1_d;  v2_q <= v2_d;  v3_q <= v3_d;  v4_q <= v4_d;
            x1_q <= x1_d;  y1_q <= y1_d;  c1_q <= c1_d;
            cps1_q <= cps1_d;  cms1_q <= cms1_d;  xmy1_q <= xmy1_d;
            xmyc2_q <= xmyc2_d;  cmsy2_q <= cmsy2_d;  cpsx2_q <= cpsx2_d;
            r3_q <= r3_d;  i3_q <= i3_d;
            r4_q <= r4_d;  i4_q <= i4_d;
            ovf_q <= ovf_d;  ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign in_ready   = advance;
    assign out_valid  = v4_q;
    assign r_out      = r4_q;
    assign i_out      = i4_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = ovf_sticky_q;
endmodule
